mux_scan_selector: RTL and testbench
====================================

MUX_SCAN_SELECTOR -- requirements
Module: mux_scan_selector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data width of each channel in bits (WIDTH >= 1).
REQ-002 SHALL have parameter N_CH, default 4, the number of input channels (2 <= N_CH <= 16, need not be a power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port d, input, N_CH*WIDTH bits: the flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port in_valid, input, 1 bit: all channels on d are valid this cycle.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects MANUAL mode, 1 selects SCAN mode.
REQ-008 SHALL have port sel, input, $clog2(N_CH) bits: the channel index in MANUAL mode and the scan start index.
REQ-009 SHALL have port y, output, WIDTH bits: registered selected data.
REQ-010 SHALL have port y_ch, output, $clog2(N_CH) bits: the channel index that y was taken from.
REQ-011 SHALL have port y_valid, output, 1 bit: y and y_ch hold an unconsumed result.
REQ-012 SHALL have port y_ready, input, 1 bit: the downstream accepts y this cycle.
REQ-013 SHALL have port sel_err, output, 1 bit: a one-cycle pulse flagging an out-of-range sel.

Function
REQ-014 SHALL treat the output stage as free when y_valid=0 or y_ready=1; a capture occurs when in_valid=1, the stage is free, and the effective channel is legal.
REQ-015 SHALL load y=d[ch], y_ch=ch and y_valid=1 on the clock edge after a capture, giving 1-cycle latency.
REQ-016 SHALL clear y_valid when y_valid=1, y_ready=1 and no capture occurs in the same cycle.
REQ-017 SHALL hold y and y_ch stable while y_valid=1 and y_ready=0, with no data loss and no overwrite.
REQ-018 SHALL implement a state machine with two states, MANUAL and SCAN, holding an internal pointer ptr.
REQ-019 SHALL use ch=sel in MANUAL and ch=ptr in SCAN.
REQ-020 SHALL move MANUAL->SCAN on a cycle sampled with mode=1 and load ptr=sel on that edge; the first scan capture can occur on the next cycle.
REQ-021 SHALL move SCAN->MANUAL on the first cycle sampled with mode=0; no capture occurs from ptr in that cycle and ptr is retained.
REQ-022 SHALL, in SCAN, advance ptr by one only on a capture, wrapping N_CH-1 -> 0; ptr SHALL NOT advance on a stall or when in_valid=0.
REQ-023 SHALL, in MANUAL with sel >= N_CH and in_valid=1, block the capture and pulse sel_err=1 for exactly one cycle per such cycle.
REQ-024 SHALL, on a MANUAL->SCAN entry with sel >= N_CH, load ptr=0 and pulse sel_err.
REQ-025 SHALL, when a capture and a downstream acceptance happen in the same cycle, replace y with the new data and keep y_valid=1.

Reset
REQ-026 SHALL, on a rising clk edge with rst=0, set y=0, y_ch=0, y_valid=0, sel_err=0, ptr=0 and state=MANUAL.
REQ-027 SHALL discard any pending result when reset is asserted mid-operation; no capture occurs in a reset cycle.
REQ-028 SHALL allow capture from the first rising edge at which rst=1, subject to REQ-014.

Configuration
REQ-029 SHALL, when macro MUX_SCAN_SELECTOR_INVERT_EN is defined, add input port inv (1 bit) and capture y=~d[ch] on a capture with inv=1, or y=d[ch] with inv=0; the inversion is built from a 2:1 mux per bit with constant-free data paths.
REQ-030 SHALL, when MUX_SCAN_SELECTOR_INVERT_EN is undefined, have no inv port and always capture y=d[ch].

Verification
REQ-031 SHALL cover reset: hold rst=0 for 2 cycles with in_valid=1 -> y=0, y_valid=0, y_ch=0, sel_err=0.
REQ-032 SHALL cover MANUAL mode: WIDTH=8, N_CH=4, d={8'h44,8'h33,8'h22,8'h11}, sel=2, in_valid=1, y_ready=1 -> one cycle later y=8'h33, y_ch=2, y_valid=1.
REQ-033 SHALL cover scan wrap: mode=1 with sel=3, in_valid=1, y_ready=1 for 5 cycles -> y_ch sequence 3,0,1,2,3.
REQ-034 SHALL cover backpressure: y_valid=1, y_ready=0 for 3 cycles while d changes -> y and y_ch unchanged and ptr frozen; y_ready=1 -> the next channel is captured.
REQ-035 SHALL cover out-of-range sel: N_CH=3, MANUAL, sel=3, in_valid=1 for 2 cycles -> sel_err high for those 2 cycles, y_valid stays 0.
REQ-036 SHALL cover the inversion feature (MUX_SCAN_SELECTOR_INVERT_EN defined): inv=1, d[ch]=8'hA5 -> y=8'h5A.

Source files
------------

// File: rtl/mux_scan_selector.sv
// mux_scan_selector: manual or scanning channel selector with a registered valid/ready output stage.
// Optional feature macro MUX_SCAN_SELECTOR_INVERT_EN adds an inv input that inverts captured data.
module mux_scan_selector #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*WIDTH-1:0]   d,
   input  logic                    in_valid,
   input  logic                    mode,
   input  logic [$clog2(N_CH)-1:0] sel,
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
   input  logic                    inv,
`endif
   output logic [WIDTH-1:0]        y,
   output logic [$clog2(N_CH)-1:0] y_ch,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic                    sel_err
);
   localparam int SW = $clog2(N_CH);
   typedef enum logic {MANUAL, SCAN} state_t;
   state_t           state_q, state_d;
   logic [SW-1:0]    ptr_q, ptr_d, y_ch_q, y_ch_d, ch;
   logic [WIDTH-1:0] y_q, y_d, chan_data;
   logic [WIDTH-1:0] chans [N_CH];
   logic             y_valid_q, y_valid_d, sel_err_q, sel_err_d;
   logic             sel_bad, free, capture;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign chans[k] = d[k*WIDTH +: WIDTH];
   end

   always_comb begin
      sel_bad   = 32'(sel) >= N_CH;
      free      = !y_valid_q || y_ready;
      ch        = (state_q == SCAN) ? ptr_q : sel;
      // the mode-change cycle never captures, in either direction
      capture   = in_valid && free && ((state_q == SCAN) ? mode : (!mode && !sel_bad));
      chan_data = chans[ch];
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
      y_d       = capture ? (inv ? ~chan_data : chan_data) : y_q;
`else
      y_d       = capture ? chan_data : y_q;
`endif
      y_ch_d    = capture ? ch : y_ch_q;
      y_valid_d = capture || (y_valid_q && !y_ready);
      state_d   = mode ? SCAN : MANUAL;
      ptr_d     = (state_q == MANUAL && mode) ? (sel_bad ? '0 : sel) :
                  (state_q == SCAN && capture) ? ((ptr_q == SW'(N_CH-1)) ? '0 : ptr_q + SW'(1)) :
                  ptr_q;
      sel_err_d = state_q == MANUAL && sel_bad && (mode || in_valid);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= MANUAL;
         ptr_q     <= '0;
         y_q       <= '0;
         y_ch_q    <= '0;
         y_valid_q <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         y_q       <= y_d;
         y_ch_q    <= y_ch_d;
         y_valid_q <= y_valid_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign y       = y_q;
   assign y_ch    = y_ch_q;
   assign y_valid = y_valid_q;
   assign sel_err = sel_err_q;
endmodule

// File: tb/tb_mux_scan_selector.sv
// tb_mux_scan_selector: drives a 4-channel and a 3-channel selector from shared random stimulus
// and checks both against a reference model through result and per-cycle flag scoreboards.
module tb_mux_scan_selector;
   typedef struct packed {logic [7:0] y; logic [1:0] ch;} res_t;
   typedef struct {int tag; logic [1:0] v; logic [1:0] e;} flg_t;
   logic clk = 0, rst = 0, in_valid = 0, mode = 0, y_ready = 0;
   logic [1:0]  sel = 0;
   logic [31:0] dd = 0;
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
   logic inv = 0;
`endif
   logic [7:0] yo [2];
   logic [1:0] ych [2];
   logic [1:0] yv, se;
   int n_cmp = 0, n_fail = 0, edge_cnt = 0;
   res_t rq0[$], rq1[$];
   flg_t fq[$];
   logic m_scan [2];
   logic m_valid [2];
   int   m_ptr [2];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   mux_scan_selector #(.WIDTH(8), .N_CH(4)) dut4 (
      .clk(clk), .rst(rst), .d(dd), .in_valid(in_valid), .mode(mode), .sel(sel),
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
      .inv(inv),
`endif
      .y(yo[0]), .y_ch(ych[0]), .y_valid(yv[0]), .y_ready(y_ready), .sel_err(se[0]));

   mux_scan_selector #(.WIDTH(8), .N_CH(3)) dut3 (
      .clk(clk), .rst(rst), .d(dd[23:0]), .in_valid(in_valid), .mode(mode), .sel(sel),
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
      .inv(inv),
`endif
      .y(yo[1]), .y_ch(ych[1]), .y_valid(yv[1]), .y_ready(y_ready), .sel_err(se[1]));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // behavioural model of one channel count for the upcoming clock edge
   task automatic step(int i, int n, output logic v, output logic e);
      logic free, cap;
      int   ch;
      res_t r;
      cap = 0; e = 0; ch = 0;
      if (!rst) begin
         m_scan[i] = 0; m_ptr[i] = 0; m_valid[i] = 0;
         if (i == 0) rq0.delete(); else rq1.delete();
      end else begin
         free = !m_valid[i] || y_ready;
         if (!m_scan[i]) begin
            if (mode) begin
               m_scan[i] = 1;
               e = int'(sel) >= n;
               m_ptr[i] = e ? 0 : int'(sel);
            end else if (in_valid) begin
               e = int'(sel) >= n;
               cap = !e && free;
               ch = int'(sel);
            end
         end else if (!mode) m_scan[i] = 0;
         else if (in_valid && free) begin
            cap = 1;
            ch = m_ptr[i];
            m_ptr[i] = (m_ptr[i] + 1) % n;
         end
         if (cap) begin
            r.y = dd[ch*8 +: 8];
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
            if (inv) r.y = ~r.y;
`endif
            r.ch = 2'(ch);
            if (i == 0) rq0.push_back(r); else rq1.push_back(r);
            m_valid[i] = 1;
         end else if (y_ready) m_valid[i] = 0;
      end
      v = m_valid[i];
   endtask

   task automatic cycle();
      flg_t f;
      logic v0, e0, v1, e1;
      step(0, 4, v0, e0);
      step(1, 3, v1, e1);
      f.tag = edge_cnt + 1;
      f.v = {v1, v0};
      f.e = {e1, e0};
      fq.push_back(f);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : mon
      flg_t f;
      if (fq.size() > 0 && fq[0].tag == edge_cnt) begin
         f = fq.pop_front();
         chk("y_valid_n4", 32'(yv[0]), 32'(f.v[0]));
         chk("y_valid_n3", 32'(yv[1]), 32'(f.v[1]));
         chk("sel_err_n4", 32'(se[0]), 32'(f.e[0]));
         chk("sel_err_n3", 32'(se[1]), 32'(f.e[1]));
      end
      if (rst && yv[0]) begin
         chk("pending_n4", 32'(rq0.size() > 0), 1);
         if (rq0.size() > 0) begin
            chk("y_n4", 32'(yo[0]), 32'(rq0[0].y));
            chk("y_ch_n4", 32'(ych[0]), 32'(rq0[0].ch));
            if (y_ready) void'(rq0.pop_front());
         end
      end
      if (rst && yv[1]) begin
         chk("pending_n3", 32'(rq1.size() > 0), 1);
         if (rq1.size() > 0) begin
            chk("y_n3", 32'(yo[1]), 32'(rq1[0].y));
            chk("y_ch_n3", 32'(ych[1]), 32'(rq1[0].ch));
            if (y_ready) void'(rq1.pop_front());
         end
      end
   end

   initial begin
      int exp_ch [5] = '{3, 0, 1, 2, 3};
      rst = 0; in_valid = 1; mode = 0; sel = 2; y_ready = 1; dd = 32'h44332211;
      cycle();
      cycle();
      chk("rst_y", 32'(yo[0]), 0);
      chk("rst_y_ch", 32'(ych[0]), 0);
      chk("rst_y_n3", 32'(yo[1]), 0);
      rst = 1;
      cycle();
      chk("manual_y", 32'(yo[0]), 32'h33);
      chk("manual_y_ch", 32'(ych[0]), 2);
      chk("manual_valid", 32'(yv[0]), 1);
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
      inv = 1; dd = 32'h00A50000;
      cycle();
      chk("invert_y", 32'(yo[0]), 32'h5A);
      inv = 0; dd = 32'h44332211;
`endif
      sel = 3;
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk("oor_err", 32'(se[1]), 1);
         chk("oor_valid", 32'(yv[1]), 0);
      end
      mode = 1;
      cycle();
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("scan_wrap_ch", 32'(ych[0]), 32'(exp_ch[k]));
      end
      y_ready = 0;
      for (int k = 0; k < 3; k++) begin
         dd = $urandom;
         cycle();
         chk("stall_y_ch", 32'(ych[0]), 3);
      end
      y_ready = 1;
      cycle();
      chk("resume_y_ch", 32'(ych[0]), 0);
      for (int k = 0; k < 400; k++) begin
         rst = $urandom_range(0, 39) != 0;
         in_valid = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel = 2'($urandom_range(0, 3));
         y_ready = $urandom_range(0, 2) != 0;
         dd = $urandom;
`ifdef MUX_SCAN_SELECTOR_INVERT_EN
         inv = 1'($urandom_range(0, 1));
`endif
         cycle();
      end
      rst = 1; in_valid = 0; y_ready = 1;
      for (int k = 0; k < 3; k++) cycle();
      @(negedge clk);
      #1;
      chk("drain_n4", 32'(rq0.size()), 0);
      chk("drain_n3", 32'(rq1.size()), 0);
      chk("flags_done", 32'(fq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
